// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, fetch state encoding and opcode decode shared by fetch and execute
package cpu_pkg;

    localparam int CPU_OPC_W = 4;

    localparam logic [CPU_OPC_W-1:0] OPC_NOP   = 4'h0;
    localparam logic [CPU_OPC_W-1:0] OPC_LOAD  = 4'h1;
    localparam logic [CPU_OPC_W-1:0] OPC_STORE = 4'h2;
    localparam logic [CPU_OPC_W-1:0] OPC_ADD   = 4'h3;
    localparam logic [CPU_OPC_W-1:0] OPC_SUB   = 4'h4;
    localparam logic [CPU_OPC_W-1:0] OPC_JMP   = 4'h5;
    localparam logic [CPU_OPC_W-1:0] OPC_MUL   = 4'h6;
    localparam logic [CPU_OPC_W-1:0] OPC_HALT  = 4'hF;

    typedef enum logic {
        FS_IDLE = 1'b0,
        FS_REQ  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic       stop;
        logic [1:0] cnt_set;
    } decode_t;

    // Unlisted opcodes behave as a zero-step NOP so the generator never stalls on them.
    function automatic decode_t decode_opcode(input logic [CPU_OPC_W-1:0] opc);
        decode_t d;
        d.stop    = 1'b0;
        d.cnt_set = 2'd0;
        case (opc)
            OPC_NOP, OPC_JMP:    d.cnt_set = 2'd0;
            OPC_LOAD, OPC_STORE: d.cnt_set = 2'd1;
            OPC_ADD, OPC_SUB:    d.cnt_set = 2'd2;
            OPC_MUL:             d.cnt_set = 2'd3;
            OPC_HALT:            d.stop    = 1'b1;
            default:             d.cnt_set = 2'd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/opcode_decode.sv
// rtl/opcode_decode.sv - combinational opcode to {stop, cnt_set} decode
module opcode_decode
    import cpu_pkg::*;
(
    input  logic [CPU_OPC_W-1:0] i_opcode,
    output logic [1:0]           o_cnt_set,
    output logic                 o_stop
);

    decode_t w_dec;

    assign w_dec     = decode_opcode(i_opcode);
    assign o_cnt_set = w_dec.cnt_set;
    assign o_stop    = w_dec.stop;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, IR, memory read handshake and decode into cnt_set/stop
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int OPC_W       = CPU_OPC_W,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              T1_Mif,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] pc_out,
    output logic [1:0]        cnt_set,
    output logic              stop,
    output logic              done,
    output logic              fault
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_rd;
    logic [DATA_W-1:0] r_ir;
    logic [1:0]        r_cnt_set;
    logic              r_stop;
    logic              r_done;

    logic [OPC_W-1:0]  w_opcode;
    logic [1:0]        w_dec_cnt;
    logic              w_dec_stop;
    logic              w_start;
    logic              w_complete;
    logic              w_timeout;

    // Decode straight from the read data so the decoded fields land on the same edge as ir.
    assign w_opcode = mem_rdata[DATA_W-1 -: OPC_W];

    opcode_decode u_opcode_decode (
        .i_opcode  (w_opcode),
        .o_cnt_set (w_dec_cnt),
        .o_stop    (w_dec_stop)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam logic [3:0] TIMEOUT_LIM = 4'(TIMEOUT_CYC);

    logic [3:0] r_wait_cnt;
    logic       r_fault;

    assign w_timeout = (r_state == FS_REQ) && !mem_ready && (r_wait_cnt == TIMEOUT_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= 4'd0;
            r_fault    <= 1'b0;
        end else begin
            if (w_start) begin
                r_wait_cnt <= 4'd0;
            end else if ((r_state == FS_REQ) && !mem_ready && !w_timeout) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
            if (w_timeout) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign fault = r_fault;
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYC != 0);
    assign fault            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            FS_IDLE: begin
                if (T1_Mif) begin
                    w_state_nxt = FS_REQ;
                    w_start     = 1'b1;
                end
            end
            FS_REQ: begin
                if (mem_ready) begin
                    w_state_nxt = FS_IDLE;
                    w_complete  = 1'b1;
                end else if (w_timeout) begin
                    w_state_nxt = FS_IDLE;
                end
            end
            default: w_state_nxt = FS_IDLE;
        endcase
    end

    // mem_addr is captured at request start so a jump during REQ cannot retarget the read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= '0;
            r_mem_addr <= '0;
            r_mem_rd   <= 1'b0;
            r_ir       <= '0;
            r_cnt_set  <= 2'd0;
            r_stop     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_complete || w_timeout;

            if (w_start) begin
                r_mem_rd   <= 1'b1;
                r_mem_addr <= r_pc;
            end else if (w_complete || w_timeout) begin
                r_mem_rd <= 1'b0;
            end

            if (w_complete) begin
                r_ir      <= mem_rdata;
                r_cnt_set <= w_dec_cnt;
                r_stop    <= w_dec_stop;
            end else if (w_timeout) begin
                r_stop <= 1'b1;
            end

            if (pc_load) begin
                r_pc <= pc_load_val;
            end else if (w_complete) begin
                r_pc <= r_pc + ADDR_W'(1);
            end
        end
    end

    assign mem_addr = r_mem_addr;
    assign mem_rd   = r_mem_rd;
    assign ir       = r_ir;
    assign pc_out   = r_pc;
    assign cnt_set  = r_cnt_set;
    assign stop     = r_stop;
    assign done     = r_done;

endmodule
